// File: rtl/svm_eval_sequencer.sv
// svm_eval_sequencer: control FSM for the SRAM-based SVM classifier.
// It sequences the host coefficient load. It then runs one SRAM sweep per modality
// (valence, then arousal) through the shared MAC datapath. Each label is captured
// from the decision sign, and the label pair is returned on a valid/ready output.
//
// Optional feature: define SVM_SEQ_PERF_EN to add the perf_cycles port. It reports
// the number of cycles from the valence feature handshake to the label pair handshake.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_LOAD   | host writes coefficients/intercepts; leaves on mem_write_done
// S_WAIT_FIN | fin_ready high, waiting for the feature vector handshake
// S_SWEEP  | reads rows 0..F_WIDTH-1, one per cycle
// S_DRAIN  | lets the pipelined acc_en tail and the last accumulate settle
// S_DECIDE | samples dp_sign into the label of the current modality
// S_OUT    | presents the label pair until dout_ready
module svm_eval_sequencer #(
    parameter int F_WIDTH     = 214,
    parameter int LOG_F_WIDTH = 8,
    parameter int SRAM_LAT    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LOG_F_WIDTH-1:0] mem_write_addr,
    input  logic                   mem_we,
    output logic                   mem_write_ready,
    input  logic                   mem_write_done,
    input  logic                   intercept_valid,
    input  logic                   fin_valid,
    output logic                   fin_ready,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   valence,
    output logic                   arousal,
    output logic [LOG_F_WIDTH-1:0] sram_addr,
    output logic                   sram_cen,
    output logic                   sram_wen,
    output logic                   icpt_load,
    output logic                   feat_load,
    output logic                   acc_clear,
    output logic                   acc_en,
    output logic                   acc_modality,
    input  logic                   dp_sign
`ifdef SVM_SEQ_PERF_EN
    ,
    output logic [15:0]            perf_cycles
`endif
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_WAIT_FIN,
        S_SWEEP,
        S_DRAIN,
        S_DECIDE,
        S_OUT
    } state_t;

    localparam logic [LOG_F_WIDTH-1:0] ROW_LAST   = LOG_F_WIDTH'(F_WIDTH - 1);
    // DRAIN lasts SRAM_LAT+1 cycles. The extra cycle lets the final accumulate reach dp_sign.
    localparam logic [1:0]             DRAIN_LOAD = 2'(SRAM_LAT);

    state_t                state;
    logic                  m;
    logic [1:0]            drain_cnt;
    logic [SRAM_LAT-1:0]   rd_pipe;
    logic                  load_wr;

    // A host write is allowed only when the row address is inside the coefficient array.
    assign load_wr      = ~mem_we & (mem_write_addr <= ROW_LAST);
    assign feat_load    = fin_valid & fin_ready;
    assign acc_en       = rd_pipe[SRAM_LAT-1];
    assign acc_modality = m;

    // Sequencer FSM with registered outputs and the read-valid delay line that feeds acc_en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_LOAD;
            m               <= 1'b0;
            drain_cnt       <= '0;
            rd_pipe         <= '0;
            mem_write_ready <= 1'b1;
            fin_ready       <= 1'b0;
            dout_valid      <= 1'b0;
            valence         <= 1'b0;
            arousal         <= 1'b0;
            sram_addr       <= '0;
            sram_cen        <= 1'b1;
            sram_wen        <= 1'b1;
            icpt_load       <= 1'b0;
            acc_clear       <= 1'b0;
        end else begin
            acc_clear  <= 1'b0;
            icpt_load  <= 1'b0;
            rd_pipe[0] <= (state == S_SWEEP);
            for (int i = 1; i < SRAM_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            case (state)
                S_LOAD: begin
                    sram_addr <= mem_write_addr;
                    sram_cen  <= ~load_wr;
                    sram_wen  <= ~load_wr;
                    icpt_load <= intercept_valid;
                    if (mem_write_done) begin
                        state           <= S_WAIT_FIN;
                        mem_write_ready <= 1'b0;
                        fin_ready       <= 1'b1;
                        sram_cen        <= 1'b1;
                        sram_wen        <= 1'b1;
                        icpt_load       <= 1'b0;
                    end
                end
                S_WAIT_FIN: begin
                    if (fin_valid) begin
                        state     <= S_SWEEP;
                        fin_ready <= 1'b0;
                        acc_clear <= 1'b1;
                        sram_cen  <= 1'b0;
                        sram_addr <= '0;
                    end
                end
                S_SWEEP: begin
                    if (sram_addr == ROW_LAST) begin
                        sram_cen  <= 1'b1;
                        drain_cnt <= DRAIN_LOAD;
                        state     <= S_DRAIN;
                    end else begin
                        sram_addr <= sram_addr + LOG_F_WIDTH'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == 2'd0) begin
                        state <= S_DECIDE;
                    end else begin
                        drain_cnt <= drain_cnt - 2'd1;
                    end
                end
                S_DECIDE: begin
                    if (!m) begin
                        valence   <= ~dp_sign;
                        m         <= 1'b1;
                        state     <= S_WAIT_FIN;
                        fin_ready <= 1'b1;
                    end else begin
                        arousal    <= ~dp_sign;
                        m          <= 1'b0;
                        state      <= S_OUT;
                        dout_valid <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (dout_ready) begin
                        dout_valid <= 1'b0;
                        state      <= S_WAIT_FIN;
                        fin_ready  <= 1'b1;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

`ifdef SVM_SEQ_PERF_EN
    logic perf_run;

    // Saturating cycle count from the valence feature handshake to the label pair handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycles <= '0;
            perf_run    <= 1'b0;
        end else if (feat_load && !m) begin
            perf_cycles <= '0;
            perf_run    <= 1'b1;
        end else if (perf_run) begin
            if (perf_cycles != 16'hFFFF) begin
                perf_cycles <= perf_cycles + 16'd1;
            end
            if (dout_valid && dout_ready) begin
                perf_run <= 1'b0;
            end
        end
    end
`endif

endmodule
